line_fetch: RTL
===============

Name: line_fetch

Overview:
- Downstream consumer of the VGA timing generator's row_pulse, frame_pulse and active outputs.
- On each row_pulse it requests one line of RGB332 pixel bytes from the external memory streamer and buffers them in a small FIFO.
- It pops one byte per active display cycle and drives registered pixel data to the output pins.
- It tracks a per-frame line address and flags underruns.

Parameters:
- DEPTH, 16, FIFO depth in bytes; must be a power of two, minimum 4.
- ADDR_W, 24, memory byte-address width.

Ports:
- clk  input  1  system clock (same clock as the timing generator).
- rst_n  input  1  synchronous, active-low reset.
- base_addr  input  ADDR_W  start address of frame; sampled on frame_pulse and when en rises.
- line_bytes  input  11  bytes fetched per line; static while en is high.
- en  input  1  block enable; low holds the block in reset state.
- row_pulse  input  1  one-cycle pulse meaning "fetch the next line now".
- frame_pulse  input  1  one-cycle pulse at the end of the last visible pixel of a frame.
- active  input  1  display-active strobe.
- mem_start  output  1  one-cycle pulse; mem_addr and mem_len are valid in the same cycle.
- mem_addr  output  ADDR_W  line start byte address.
- mem_len  output  11  byte count for the request (equals line_bytes).
- mem_stop  output  1  one-cycle pulse that aborts the current memory stream.
- mem_data  input  8  streamed byte.
- mem_valid  input  1  mem_data is valid.
- mem_ready  output  1  block accepts mem_data this cycle.
- pixel  output  8  registered RGB332 pixel; 0 outside active.
- underrun  output  1  sticky flag: active occurred while the FIFO was empty.
- busy  output  1  a line fetch is outstanding (state is not IDLE).

Behaviour:
- Reset (rst_n low or en low), applied synchronously:
  - Outputs: mem_start=0, mem_stop=0, mem_ready=0, pixel=0, underrun=0, busy=0; mem_addr=0, mem_len=0.
  - Internal: FIFO empty; line_addr=base_addr; state=IDLE; byte counter=0.
- States:
  - IDLE:
    - row_pulse → START.
  - START (one cycle):
    - mem_start=1, mem_addr=line_addr, mem_len=line_bytes.
    - Load byte counter with line_bytes, then line_addr += line_bytes (wraps modulo 2^ADDR_W).
    - Next state STREAM. If line_bytes==0, go to IDLE instead; mem_start still pulses.
  - STREAM:
    - mem_ready = !fifo_full, combinational from registered FIFO state.
    - On mem_valid && mem_ready: push mem_data and decrement the counter. When the counter reaches 0 after a push, → IDLE.
- FIFO:
  - Push and pop are allowed in the same cycle when the FIFO is neither empty nor full.
  - When full, a simultaneous pop does not enable a push, because mem_ready was already low.
  - Occupancy ranges 0..DEPTH.
- Pixel output (1-cycle latency):
  - Cycle n, active=1 and FIFO not empty: pop the head; pixel=head at n+1.
  - Cycle n, active=1 and FIFO empty: pixel=0 at n+1 and underrun set at n+1.
  - Cycle n, active=0: pixel=0 at n+1, no pop.
  - Downstream output logic delays hsync/vsync by 1 cycle to align with pixel.
- frame_pulse:
  - The pixel pop for that cycle still occurs, since active is also high.
  - Effects at the next edge: FIFO flushed, line_addr=base_addr, underrun cleared.
  - If state is START or STREAM: mem_stop=1 for one cycle and state → IDLE. Any byte offered in that cycle is dropped.
  - Priority: flush happens after the pop, and the underrun clear overrides a set in the same cycle.
- row_pulse while START/STREAM (late fetch):
  - The new request is latched as pending and serviced on return to IDLE. It enters START on the cycle after the IDLE entry cycle.
  - Only one request is held pending; further pulses are dropped.
- row_pulse and frame_pulse in the same cycle: frame_pulse is applied first, then START issues using base_addr.
- mem_data is ignored outside STREAM; mem_ready=0 outside STREAM.

Test Plan:
- Basic fetch:
  - Stimulus: reset, en=1, base_addr=0x100000, line_bytes=8, row_pulse, then memory streams 0x01..0x08 with mem_valid always high.
  - Response: mem_start with mem_addr=0x100000, mem_len=8; 8 pushes; busy falls. Eight active cycles give pixel=0x01..0x08 one cycle later; underrun=0.
- Address advance:
  - Stimulus: three row_pulses with line_bytes=640, then frame_pulse, then row_pulse.
  - Response: mem_addr=0x100000, 0x100280, 0x100500, then 0x100000 again.
- Back-pressure:
  - Stimulus: DEPTH=16, line_bytes=20, active held low.
  - Response: mem_ready drops after 16 pushes. Raising active resumes the stream with exactly one push per pop; all 20 bytes are delivered in order.
- Underrun:
  - Stimulus: line_bytes=4, memory supplies 4 bytes, active held for 6 cycles.
  - Response: last two pixels=0; underrun=1 and held until the cycle after frame_pulse.
- Abort:
  - Stimulus: frame_pulse mid-STREAM with 3 of 8 bytes received.
  - Response: mem_stop pulses once; FIFO empty; state IDLE; a subsequent row_pulse issues mem_addr=base_addr.
- Reset mid-operation and pending request:
  - Stimulus: row_pulse during STREAM, then en dropped low mid-pending.
  - Response: all outputs return to 0 and no START is issued. Without the en drop, the pending START fires the cycle after entry to IDLE.

Source files
------------

// File: rtl/line_fetch.sv
// Line fetcher: requests one line of RGB332 bytes per row_pulse and streams them to the pixel pins.
// Latency: mem_start one cycle after row_pulse in IDLE; pixel registered one cycle after the active pop.
// Backpressure: mem_ready falls while the byte FIFO is full; an active cycle with an empty FIFO sets underrun.

// Byte FIFO with show-ahead read data and a synchronous flush.
// Latency: a pushed byte is visible at rd_dat on the cycle after the push.
// Backpressure: pushes are ignored when full and pops are ignored when empty.
module line_fetch_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         flush,
   input  logic         wr_vld,
   input  logic [W-1:0] wr_dat,
   output logic         full,
   input  logic         rd_en,
   output logic [W-1:0] rd_dat,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  store [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_wr;
   logic          do_rd;

   assign full   = (count == (AW+1)'(DEPTH));
   assign empty  = (count == '0);
   assign do_wr  = wr_vld && !full;
   assign do_rd  = rd_en && !empty;
   assign rd_dat = store[rd_ptr];

   // Storage array; no reset needed since count gates every read.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         store[wr_ptr] <= wr_dat;
      end
   end

   // Pointer and occupancy bookkeeping; flush discards contents after any same-cycle read.
   always_ff @(posedge clk) begin
      if (clr || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_wr, do_rd})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

module line_fetch #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 24
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [10:0]       line_bytes,
   input  logic              en,
   input  logic              row_pulse,
   input  logic              frame_pulse,
   input  logic              active,
   output logic              mem_start,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [10:0]       mem_len,
   output logic              mem_stop,
   input  logic [7:0]        mem_data,
   input  logic              mem_valid,
   output logic              mem_ready,
   output logic [7:0]        pixel,
   output logic              underrun,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      START  = 2'd1,
      STREAM = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              clr;
   logic              in_fetch;
   logic [ADDR_W-1:0] line_addr;
   logic [10:0]       byte_cnt;
   logic              pending;
   logic              push_vld;
   logic              pop_en;
   logic              fifo_full;
   logic              fifo_empty;
   logic [7:0]        head_dat;

   // en low behaves exactly like reset so the block restarts cleanly when re-enabled.
   assign clr      = !rst_n || !en;
   assign in_fetch = (state == START) || (state == STREAM);

   // Request outputs are driven only during the START cycle and read zero otherwise.
   assign mem_start = (state == START);
   assign mem_addr  = (state == START) ? line_addr  : '0;
   assign mem_len   = (state == START) ? line_bytes : '0;
   assign busy      = (state != IDLE);

   // Ready depends only on registered state; a byte offered during frame_pulse is dropped.
   assign mem_ready = (state == STREAM) && !fifo_full;
   assign push_vld  = mem_valid && mem_ready && !frame_pulse;
   assign pop_en    = active && !fifo_empty;

   line_fetch_fifo #(
      .DEPTH (DEPTH),
      .W     (8)
   ) u_fifo (
      .clk    (clk),
      .clr    (clr),
      .flush  (frame_pulse),
      .wr_vld (push_vld),
      .wr_dat (mem_data),
      .full   (fifo_full),
      .rd_en  (pop_en),
      .rd_dat (head_dat),
      .empty  (fifo_empty)
   );

   // Next-state logic; frame_pulse aborts any fetch, and a coincident row_pulse starts afresh from base_addr.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (row_pulse || pending) begin
               state_nxt = START;
            end
         end
         START: begin
            state_nxt = (line_bytes == 11'd0) ? IDLE : STREAM;
         end
         STREAM: begin
            if (push_vld && (byte_cnt == 11'd1)) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (frame_pulse) begin
         state_nxt = row_pulse ? START : IDLE;
      end
   end

   // State, line address, byte counter, pending request and abort pulse.
   always_ff @(posedge clk) begin
      if (clr) begin
         state     <= IDLE;
         line_addr <= base_addr;
         byte_cnt  <= '0;
         pending   <= 1'b0;
         mem_stop  <= 1'b0;
      end else begin
         state    <= state_nxt;
         mem_stop <= frame_pulse && in_fetch;

         if (frame_pulse) begin
            line_addr <= base_addr;
         end else if (state == START) begin
            line_addr <= line_addr + ADDR_W'(line_bytes);
         end

         if (state == START) begin
            byte_cnt <= line_bytes;
         end else if (push_vld) begin
            byte_cnt <= byte_cnt - 11'd1;
         end

         // Only one late request is remembered; a new frame discards it.
         if (frame_pulse) begin
            pending <= 1'b0;
         end else if ((state == IDLE) && (state_nxt == START)) begin
            pending <= 1'b0;
         end else if (row_pulse && in_fetch) begin
            pending <= 1'b1;
         end
      end
   end

   // Registered pixel and sticky underrun; frame_pulse clear wins over a same-cycle set.
   always_ff @(posedge clk) begin
      if (clr) begin
         pixel    <= '0;
         underrun <= 1'b0;
      end else begin
         pixel <= pop_en ? head_dat : 8'h00;
         if (frame_pulse) begin
            underrun <= 1'b0;
         end else if (active && fifo_empty) begin
            underrun <= 1'b1;
         end
      end
   end

endmodule
